// File: rtl/refemv_mem_if.sv
// CPU-side memory bus plus the UART serial line for refemv_mem.
// master: the CPU driving addresses/strobes; slave: the memory/IO block.
interface refemv_mem_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        uart_tx;

  modport master (
    output mem_addr, mem_wdata, mem_rstrb, mem_wmask,
    input  mem_rdata, uart_tx
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rstrb, mem_wmask,
    output mem_rdata, uart_tx
  );
endinterface

// File: rtl/refemv_mem.sv
// refemv_mem: word RAM with byte-lane writes plus an IO page holding a
// buffered 8N1 UART transmitter and its status register.
// Optional feature macro: MMIO_TIMER_EN adds a free-running cycle counter
// readable at IO index 2 (reads as 0 when the macro is undefined).
module refemv_mem #(
  parameter int RAM_WORDS  = 4096,
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 8
) (
  input logic         clk,
  input logic         rstn,
  refemv_mem_if.slave bus
);
  localparam int RAW = $clog2(RAM_WORDS);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0]  CYC_LAST = CW'(CLK_DIV - 1);
  localparam logic [FAW:0]   FIFO_CNT_FULL = (FAW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Address decode: bit 22 picks the IO page, RAM aliases above its depth.
  logic           io_sel;
  logic [2:0]     io_idx;
  logic [RAW-1:0] ram_idx;
  logic           ram_we;
  logic           push_req;
  logic           status_wr;
  logic           addr_unused;

  assign io_sel      = bus.mem_addr[22];
  assign io_idx      = bus.mem_addr[4:2];
  assign ram_idx     = bus.mem_addr[RAW+1:2];
  assign ram_we      = !io_sel && (bus.mem_wmask != 4'b0000);
  assign push_req    = io_sel && (io_idx == 3'd0) && bus.mem_wmask[0];
  assign status_wr   = io_sel && (io_idx == 3'd1) && (bus.mem_wmask != 4'b0000);
  assign addr_unused = ^{bus.mem_addr[31:23], bus.mem_addr[21:RAW+2], bus.mem_addr[1:0]};

  logic [31:0] ram [RAM_WORDS];
  logic [31:0] rdata;
  logic [31:0] io_rdata;

  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [FAW:0] wr_ptr, rd_ptr, fifo_count;
  logic        fifo_full, fifo_empty, pop, push;
  logic        overflow;

  tx_state_t   state, state_next;
  logic [CW-1:0] cyc;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        bit_end;
  logic        tx, tx_busy;

`ifdef MMIO_TIMER_EN
  logic [31:0] timer;

  // Free-running cycle counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rstn) timer <= '0;
    else       timer <= timer + 32'd1;
  end
`endif

  // Byte-lane RAM writes; contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_wmask[b]) ram[ram_idx][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
    end
  end

  // IO register read mux; index 0 and unmapped indices read as zero.
  always_comb begin
    io_rdata = '0;
    case (io_idx)
      3'd1:    io_rdata = {29'b0, overflow, fifo_full, tx_busy};
`ifdef MMIO_TIMER_EN
      3'd2:    io_rdata = timer;
`endif
      default: io_rdata = '0;
    endcase
  end

  // Registered read port; RAM read sees the pre-write word (read-before-write).
  always_ff @(posedge clk) begin
    if (!rstn)              rdata <= '0;
    else if (bus.mem_rstrb) rdata <= io_sel ? io_rdata : ram[ram_idx];
  end

  assign bus.mem_rdata = rdata;

  // FIFO flags: extra pointer bit distinguishes full from empty.
  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_full  = (fifo_count == FIFO_CNT_FULL);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign pop        = (state == IDLE) && !fifo_empty;
  assign push       = push_req && (!fifo_full || pop);

  // FIFO storage; a push into a full FIFO that pops this cycle reuses the freed slot.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[FAW-1:0]] <= bus.mem_wdata[7:0];
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (status_wr)                            overflow <= 1'b0;
      else if (push_req && fifo_full && !pop)   overflow <= 1'b1;
    end
  end

  assign bit_end = (cyc == CYC_LAST);

  // TX FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // TX FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty)                state_next = START;
      START:   if (bit_end)                    state_next = DATA;
      DATA:    if (bit_end && bit_cnt == 3'd7) state_next = STOP;
      STOP:    if (bit_end)                    state_next = IDLE;
      default:                                 state_next = IDLE;
    endcase
  end

  // TX FSM outputs: line level and busy flag.
  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shreg[0];
      default: tx = 1'b1;
    endcase
    tx_busy = (state != IDLE) || !fifo_empty;
  end

  assign bus.uart_tx = tx;

  // Bit-period and bit-index counters, held at zero while idle.
  always_ff @(posedge clk) begin
    if (!rstn || state == IDLE) begin
      cyc     <= '0;
      bit_cnt <= '0;
    end else if (bit_end) begin
      cyc <= '0;
      if (state == DATA) bit_cnt <= bit_cnt + 3'd1;
    end else begin
      cyc <= cyc + 1'b1;
    end
  end

  // Shift register: loaded on pop, shifted LSB-first at each data bit end.
  always_ff @(posedge clk) begin
    if (pop)                          shreg <= fifo_mem[rd_ptr[FAW-1:0]];
    else if (state == DATA && bit_end) shreg <= {1'b0, shreg[7:1]};
  end
endmodule

// File: doc/refemv_mem.md
REFEMV_MEM -- requirements
Module: refemv_mem

Interface
REQ-001 Parameter RAM_WORDS, default 4096, SHALL set the RAM depth in 32-bit words, a power of two.
REQ-002 Parameter CLK_DIV, default 434, SHALL set the clock cycles per UART bit.
REQ-003 Parameter FIFO_DEPTH, default 8, SHALL set the UART TX FIFO entries, a power of two.
REQ-004 clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rstn  in  1  SHALL be the reset: synchronous, active-low.
REQ-006 mem_addr  in  32  SHALL be the CPU byte address.
REQ-007 mem_wdata  in  32  SHALL be the store data, already lane-replicated by the CPU.
REQ-008 mem_rstrb  in  1  SHALL be the read strobe.
REQ-009 mem_wmask  in  4  SHALL be the byte-lane write enables; bit n enables byte n.
REQ-010 mem_rdata  out  32  SHALL be the registered read data.
REQ-011 uart_tx  out  1  SHALL be the 8N1 serial output, idle high.

Function
REQ-012 Address decode SHALL be: mem_addr[22]=0 selects RAM; =1 selects IO; IO register index = mem_addr[4:2].
REQ-013 RAM word index SHALL be mem_addr[log2(RAM_WORDS)+1:2]; higher address bits ignored (aliasing).
REQ-014 On an edge with mem_rstrb=1, mem_rdata SHALL load the selected word; it is valid the following cycle and held until the next strobe.
REQ-015 On an edge with mem_wmask!=0 to RAM, only enabled byte lanes SHALL be written from mem_wdata.
REQ-016 Simultaneous read and write to the same RAM word SHALL return the old data (read-before-write).
REQ-017 IO index 0 (UART_DATA) write with mem_wmask[0]=1 SHALL push mem_wdata[7:0] into the FIFO if not full.
REQ-018 A push while full SHALL be dropped and SHALL set sticky overflow; if a pop occurs the same cycle, the push SHALL be accepted.
REQ-019 IO index 1 (UART_STATUS) read SHALL return {29'b0, overflow, fifo_full, tx_busy}; a write with any mask bit set SHALL clear overflow.
REQ-020 Reads of IO index 0 and unmapped indices SHALL return 0; writes to them SHALL be ignored.
REQ-021 TX FSM states SHALL be IDLE, START, DATA, STOP, with each non-IDLE bit lasting exactly CLK_DIV cycles.
REQ-022 In IDLE with FIFO non-empty, the FSM SHALL pop one byte and enter START; uart_tx goes low on the next cycle.
REQ-023 DATA SHALL shift 8 bits LSB first; STOP drives 1, then the FSM returns to IDLE, so a frame lasts 10*CLK_DIV cycles.
REQ-024 Back-to-back queued bytes SHALL be sent with at most 1 idle cycle between frames.
REQ-025 tx_busy SHALL be 1 in any state other than IDLE or when the FIFO is non-empty.
REQ-026 FIFO count SHALL use wrap-around pointers and SHALL never exceed FIFO_DEPTH or underflow.

Reset
REQ-027 rstn=0 at an edge SHALL set mem_rdata=0, uart_tx=1, TX FSM=IDLE, FIFO empty, overflow=0, and bit and cycle counters to 0.
REQ-028 Reset mid-frame SHALL abort the frame, with uart_tx high the next cycle; queued bytes are discarded.
REQ-029 RAM contents SHALL NOT be altered by reset.

Configuration
REQ-030 With macro MMIO_TIMER_EN defined, IO index 2 SHALL read a 32-bit free-running cycle counter: reset to 0, +1 per cycle, wraps at 2^32, writes ignored.
REQ-031 Without MMIO_TIMER_EN, IO index 2 SHALL read 0 and no counter register SHALL exist.

Verification
REQ-032 Write 0xDEADBEEF with mask 1111 to 0x100, strobe a read at 0x100 -> mem_rdata=0xDEADBEEF the next cycle.
REQ-033 Then write 0x00AA0000 with mask 0100 to 0x100, read -> 0xDEAABEEF; a read at 0x100+RAM_WORDS*4 returns the same value.
REQ-034 CLK_DIV=4; write 0x55 to 0x400000 -> uart_tx=0 for 4 cycles, then 1,0,1,0,1,0,1,0 for 4 cycles each, then 1 for 4 cycles; tx_busy drops afterwards.
REQ-035 CLK_DIV=4; push 10 bytes back-to-back -> first 9 accepted (1 popped plus 8 queued), 10th dropped; STATUS reads 0x7 before draining.
REQ-036 Assert rstn=0 for 1 cycle mid-DATA -> next cycle uart_tx=1, STATUS=0, and the previously written RAM word is unchanged.
REQ-037 With MMIO_TIMER_EN, two reads of 0x400008 issued 5 cycles apart -> values differ by 5; without it -> both 0.
